// File: rtl/bus_drive_ctrl.sv
// Feeds a tri-state bus stage: buffers bytes in a small circular FIFO and sequences
// them onto the bus as enable-high hold periods separated by enable-low turnaround gaps.
module bus_drive_ctrl #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [DATA_W-1:0]          wr_data_in,
    input  logic                       wr_valid_in,
    output logic                       wr_ready_out,
    input  logic                       grant_in,
    output logic [DATA_W-1:0]          data_bus_out,
    output logic                       en_out,
    output logic                       busy_out,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       sent_out
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PH_MAX = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0]  TURN_LAST = PH_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        TURN
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              start;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign wr_ready_out = (count < FULL_CNT);
    assign count_out    = count;
    assign push         = wr_valid_in && wr_ready_out;
    assign start        = (count != '0) && grant_in;

    always_comb begin
        state_n = state;
        phase_n = phase;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DRIVE;
                    phase_n = '0;
                    pop     = 1'b1;
                end
            end
            DRIVE: begin
                if (phase == HOLD_LAST) begin
                    phase_n = '0;
                    if (TURN_CYCLES > 0) begin
                        state_n = TURN;
                    end else if (start) begin
                        state_n = DRIVE;
                        pop     = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end
            TURN: begin
                if (phase == TURN_LAST) begin
                    phase_n = '0;
                    if (start) begin
                        state_n = DRIVE;
                        pop     = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            phase        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_bus_out <= '0;
            en_out       <= 1'b0;
            sent_out     <= 1'b0;
            busy_out     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            en_out   <= (state_n == DRIVE);
            sent_out <= (state_n == DRIVE) && (phase_n == HOLD_LAST);
            busy_out <= (state_n != IDLE);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                data_bus_out <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !rst_in) begin
            mem[wr_ptr] <= wr_data_in;
        end
    end

endmodule
